// File: rtl/arcade_ioctl_pkg.sv
// Shared ioctl definitions for the arcade core: address width, file indices and upload FSM states.
package arcade_ioctl_pkg;

    localparam int IOCTL_ADDR_W = 25;

    localparam logic [7:0] IDX_ROM     = 8'd0;
    localparam logic [7:0] IDX_DIP     = 8'd254;
    localparam logic [7:0] IDX_HISCORE = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READY,
        ST_LAT,
        ST_DONE
    } upload_state_e;

    function automatic logic is_known_index(input logic [7:0] idx);
        return (idx == IDX_ROM) || (idx == IDX_DIP) || (idx == IDX_HISCORE);
    endfunction

endpackage

// File: rtl/upload_lat_ctr.sv
// Memory read-latency down-counter: loaded when a read is issued, flags the cycle mem_q is valid.
module upload_lat_ctr #(
    parameter int RD_LAT = 2
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic load_i,
    input  logic active_i,
    output logic valid_o
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: next-state starts from the held value so every path assigns cnt_d and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(RD_LAT);
        end else if (active_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: registered state uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign valid_o = active_i && (cnt_q == '0);

endmodule

// File: rtl/ioctl_upload_reader.sv
// HPS ioctl upload responder: serves each ioctl_rd strobe from a synchronous core memory.
// Define UPLOAD_CHECKSUM_EN to return the session checksum for a read at addr == MEM_SIZE.
module ioctl_upload_reader
    import arcade_ioctl_pkg::*;
#(
    parameter int         ADDR_W       = 10,
    parameter int         MEM_SIZE     = 1024,
    parameter int         RD_LAT       = 2,
    parameter logic [7:0] UPLOAD_INDEX = IDX_HISCORE,
    parameter logic [7:0] PAD_BYTE     = 8'hFF
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    ioctl_upload,
    input  logic                    ioctl_rd,
    input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]              ioctl_index,
    output logic [7:0]              ioctl_din,
    output logic                    ioctl_wait,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_rd,
    input  logic [7:0]              mem_q,
    output logic                    busy,
    output logic                    done,
    output logic [IOCTL_ADDR_W-1:0] byte_count,
    output logic                    proto_err
);

    localparam logic [IOCTL_ADDR_W-1:0] MEM_SIZE_A = IOCTL_ADDR_W'(MEM_SIZE);

    upload_state_e             state_q, state_d;
    logic                      upload_q;
    logic [7:0]                din_q, din_d;
    logic                      wait_q, wait_d;
    logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
    logic                      mem_rd_q, mem_rd_d;
    logic [IOCTL_ADDR_W-1:0]   count_q, count_d, count_inc;
    logic                      perr_q, perr_d;
    logic                      start, in_range, lat_load, lat_valid;
    logic [7:0]                pad_value;

    assign start     = ioctl_upload && !upload_q && (ioctl_index == UPLOAD_INDEX);
    assign in_range  = ioctl_addr < MEM_SIZE_A;
    assign count_inc = (count_q == '1) ? count_q : count_q + IOCTL_ADDR_W'(1);

`ifdef UPLOAD_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    assign pad_value = (ioctl_addr == MEM_SIZE_A) ? (~sum_q + 8'd1) : PAD_BYTE;
`else
    assign pad_value = PAD_BYTE;
`endif

    upload_lat_ctr #(.RD_LAT(RD_LAT)) u_lat_ctr (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .load_i   (lat_load),
        .active_i (state_q == ST_LAT),
        .valid_o  (lat_valid)
    );

    always_comb begin
        state_d    = state_q;
        din_d      = din_q;
        wait_d     = wait_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        count_d    = count_q;
        perr_d     = perr_q;
        lat_load   = 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_READY;
                    count_d = '0;
                    perr_d  = 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            ST_READY: begin
                if (!ioctl_upload) begin
                    state_d = ST_DONE;
                    wait_d  = 1'b0;
                end else if (ioctl_rd) begin
                    if (in_range) begin
                        mem_addr_d = ioctl_addr[ADDR_W-1:0];
                        mem_rd_d   = 1'b1;
                        wait_d     = 1'b1;
                        lat_load   = 1'b1;
                        state_d    = ST_LAT;
                    end else begin
                        din_d   = pad_value;
                        count_d = count_inc;
                    end
                end
            end
            ST_LAT: begin
                // Upload end abandons the pending read; a late strobe is flagged but not serviced.
                if (!ioctl_upload) begin
                    state_d = ST_DONE;
                    wait_d  = 1'b0;
                end else begin
                    if (ioctl_rd) perr_d = 1'b1;
                    if (lat_valid) begin
                        din_d   = mem_q;
                        wait_d  = 1'b0;
                        count_d = count_inc;
                        state_d = ST_READY;
`ifdef UPLOAD_CHECKSUM_EN
                        sum_d   = sum_q + mem_q;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            upload_q   <= 1'b0;
            din_q      <= '0;
            wait_q     <= 1'b0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            count_q    <= '0;
            perr_q     <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            upload_q   <= ioctl_upload;
            din_q      <= din_d;
            wait_q     <= wait_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            count_q    <= count_d;
            perr_q     <= perr_d;
`ifdef UPLOAD_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign byte_count = count_q;
    assign proto_err  = perr_q;
    assign busy       = (state_q == ST_READY) || (state_q == ST_LAT);
    assign done       = (state_q == ST_DONE);

endmodule

// File: doc/ioctl_upload_reader.md
Name: ioctl_upload_reader

Overview:
- Responder for the HPS ioctl upload direction. It is the read-back counterpart of the ROM/DIP download path.
- When the HPS uploads a file with a matching index, it services each ioctl_rd strobe by reading a byte from a core-side synchronous memory (hiscore/NVRAM). The byte is returned on ioctl_din, and ioctl_wait stretches the transfer.
- Sits between hps_io and a true-dual-port RAM inside the core, in the clk_sys domain.

Parameters:
- ADDR_W, 10, width of mem_addr.
- MEM_SIZE, 1024, number of valid bytes; reads at or above this return pad.
- RD_LAT, 2, memory read latency in cycles from mem_rd to mem_q valid (1..4).
- UPLOAD_INDEX, 8'd4, ioctl_index value this block responds to.
- PAD_BYTE, 8'hFF, value returned for out-of-range addresses.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous active-high reset
- ioctl_upload  in  1  HPS upload session active
- ioctl_rd  in  1  one-cycle read strobe; ioctl_addr valid same cycle
- ioctl_addr  in  25  byte address
- ioctl_index  in  8  file index
- ioctl_din  out  8  read data to HPS
- ioctl_wait  out  1  stall request to HPS
- mem_addr  out  ADDR_W  memory read address
- mem_rd  out  1  one-cycle memory read enable
- mem_q  in  8  memory read data
- busy  out  1  high while a session is active and selected
- done  out  1  one-cycle pulse at session end
- byte_count  out  25  reads serviced in the last or current session
- proto_err  out  1  sticky: ioctl_rd received while a read was pending

Behaviour:
- Reset values: ioctl_din=0, ioctl_wait=0, mem_addr=0, mem_rd=0, busy=0, done=0, byte_count=0, proto_err=0. State is IDLE.
- The block is selected when ioctl_upload=1 and ioctl_index==UPLOAD_INDEX. ioctl_index is sampled on the rising edge of ioctl_upload.
- Rising edge of a selected upload: byte_count and proto_err clear, busy goes to 1.

FSM states: IDLE, READY, LAT, DONE.
- IDLE: on a selected-upload rising edge, go to READY.
- READY, on ioctl_rd at cycle T with addr < MEM_SIZE:
  - at T+1: mem_addr = addr[ADDR_W-1:0], mem_rd = 1 for one cycle, ioctl_wait = 1; go to LAT.
- LAT: counts RD_LAT cycles; mem_q is valid at T+1+RD_LAT.
  - at T+2+RD_LAT: ioctl_din = mem_q and ioctl_wait = 0 in the same cycle; byte_count increments; return to READY.
  - Total latency from strobe to data is RD_LAT+2 cycles.
- READY, on ioctl_rd with addr >= MEM_SIZE:
  - no memory access, wait stays 0;
  - at T+1: ioctl_din = PAD_BYTE and byte_count increments.
- ioctl_rd seen in LAT: ignored and proto_err set; the pending read completes normally.
- ioctl_din holds its last value between reads.
- ioctl_upload falls (any state): go to DONE.
  - Any pending read is abandoned: mem_rd is not reissued, and ioctl_wait is forced to 0 that cycle.
  - DONE lasts one cycle: done = 1, busy = 0; then go to IDLE.
  - byte_count holds until the next session.
- Unselected upload (index mismatch): stays IDLE; all outputs hold; no done pulse.
- Synchronous reset mid-read: immediate return to reset values; no done pulse.
- byte_count saturates at 2^25-1.

Optional Feature:
- Macro: UPLOAD_CHECKSUM_EN.
- With it:
  - an 8-bit running sum accumulates every mem_q byte returned in the session; it clears on session start;
  - a read at addr == MEM_SIZE returns the two's-complement checksum (-sum mod 256) instead of PAD_BYTE, with pad-read timing (T+1);
  - addr > MEM_SIZE still returns PAD_BYTE.
- Without it: no sum register; addr == MEM_SIZE returns PAD_BYTE.

Decomposition:
- Shared package arcade_ioctl_pkg holds:
  - the state enum typedef;
  - IOCTL_ADDR_W=25;
  - the index constants (ROM=0, DIP=254, HISCORE=4).
- One natural sub-module: upload_lat_ctr, a RD_LAT-parameterised down-counter producing the data-valid strobe. The rest stays flat.

Test Plan:
- Default params, mem[0x010]=8'hA5, selected upload, ioctl_rd addr=0x010 at T -> mem_rd and mem_addr=0x010 at T+1; ioctl_wait high T+1..T+3; ioctl_din=8'hA5 with wait low at T+4; byte_count=1.
- Sequential reads addr 0..1023 with wait honoured, then upload falls -> every byte matches memory; done pulses exactly one cycle; byte_count=1024; busy=0.
- ioctl_rd addr=0x500 (>=1024) -> ioctl_din=8'hFF at T+1; no mem_rd; wait never asserted.
- Second ioctl_rd one cycle after the first -> proto_err=1; first read still returns correct data; byte_count=1.
- Upload falls during LAT, and separately reset asserted during LAT -> wait drops next cycle; with reset all outputs return to 0 and done stays 0.
- UPLOAD_CHECKSUM_EN, MEM_SIZE=4, mem={01,02,03,04}: read 0..4 -> addr 4 returns 8'hF6; ioctl_index=0 upload -> no response, busy stays 0.
